// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: EXE command codes and status bit indices.
// Used by the control unit, the EXE stage and the ID-stage condition checker.
package arm_pkg;

    // Execute-stage command codes
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    // Bit positions inside the {N,Z,C,V} status word
    localparam int STATUS_N = 3;
    localparam int STATUS_Z = 2;
    localparam int STATUS_C = 1;
    localparam int STATUS_V = 0;

    // True for every command the ALU implements
    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        logic legal;
        case (cmd)
            EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB,
            EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational EXE-stage ALU: result plus next {N,Z,C,V}.
// C and V pass through unchanged for logical/move commands; the incoming
// flags always come from the registered status, never from this result.
module exe_alu
    import arm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        i_cmd,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    input  logic              i_c,
    input  logic              i_v,
    output logic [DATA_W-1:0] o_res,
    output logic [3:0]        o_nzcv,
    output logic              o_legal
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_b;
    logic              w_cin;
    logic              w_arith;
    logic              w_c;
    logic              w_v;

    // Operand conditioning: subtraction is op1 + ~op2 + carry-in (NOT borrow)
    always_comb begin
        w_b     = i_op2;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (i_cmd)
            EXE_ADD: begin w_b = i_op2;  w_cin = 1'b0; w_arith = 1'b1; end
            EXE_ADC: begin w_b = i_op2;  w_cin = i_c;  w_arith = 1'b1; end
            EXE_SUB: begin w_b = ~i_op2; w_cin = 1'b1; w_arith = 1'b1; end
            EXE_SBC: begin w_b = ~i_op2; w_cin = i_c;  w_arith = 1'b1; end
            default: begin w_b = i_op2;  w_cin = 1'b0; w_arith = 1'b0; end
        endcase
    end

    assign w_sum = {1'b0, i_op1} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_cin};

    // Result selection and carry/overflow generation
    always_comb begin
        o_res = '0;
        w_c   = i_c;
        w_v   = i_v;
        case (i_cmd)
            EXE_MOV: o_res = i_op2;
            EXE_MVN: o_res = ~i_op2;
            EXE_AND: o_res = i_op1 & i_op2;
            EXE_ORR: o_res = i_op1 | i_op2;
            EXE_EOR: o_res = i_op1 ^ i_op2;
            EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
                o_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                // Same-sign addends producing a different-sign sum; for
                // subtraction the addend is ~op2, which covers the SUB rule.
                w_v   = (i_op1[DATA_W-1] == w_b[DATA_W-1]) &&
                        (w_sum[DATA_W-1] != i_op1[DATA_W-1]);
            end
            default: o_res = '0;
        endcase
        if (!w_arith) begin
            w_c = i_c;
            w_v = i_v;
        end else begin
            w_c = w_c;
            w_v = w_v;
        end
    end

    // Pack flags into the shared status layout
    always_comb begin
        o_nzcv           = 4'b0000;
        o_nzcv[STATUS_N] = o_res[DATA_W-1];
        o_nzcv[STATUS_Z] = (o_res == {DATA_W{1'b0}});
        o_nzcv[STATUS_C] = w_c;
        o_nzcv[STATUS_V] = w_v;
    end

    assign o_legal = is_legal_cmd(i_cmd);

endmodule

// File: rtl/exe_alu_status.sv
// EXE stage of the 5-stage ARM pipeline: ALU, EXE/MEM result/valid registers
// and the {N,Z,C,V} status register read by the ID-stage condition checker.
// Stall freezes every register; flush kills the incoming instruction.
module exe_alu_status
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [CMD_W-1:0]  exe_cmd_i,
    input  logic              s_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] alu_res_o,
    output logic              valid_o,
    output logic [3:0]        status_o
);

    logic [DATA_W-1:0] r_alu_res;
    logic              r_valid;
    logic [3:0]        r_status;

    logic [DATA_W-1:0] w_res;
    logic [3:0]        w_nzcv;
    logic              w_legal;
    logic              w_flag_upd;

    exe_alu #(
        .DATA_W (DATA_W)
    ) u_exe_alu (
        .i_cmd   (exe_cmd_i[3:0]),
        .i_op1   (op1_i),
        .i_op2   (op2_i),
        .i_c     (r_status[STATUS_C]),
        .i_v     (r_status[STATUS_V]),
        .o_res   (w_res),
        .o_nzcv  (w_nzcv),
        .o_legal (w_legal)
    );

    assign w_flag_upd = valid_i & s_i & w_legal;

    // Pipeline registers with stall > flush > normal priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_res <= '0;
            r_valid   <= 1'b0;
            r_status  <= 4'b0000;
        end else if (stall_i) begin
            r_alu_res <= r_alu_res;
            r_valid   <= r_valid;
            r_status  <= r_status;
        end else if (flush_i) begin
            r_alu_res <= '0;
            r_valid   <= 1'b0;
            r_status  <= r_status;
        end else begin
            r_alu_res <= w_res;
            r_valid   <= valid_i;
            if (w_flag_upd) begin
                r_status <= w_nzcv;
            end else begin
                r_status <= r_status;
            end
        end
    end

    assign alu_res_o = r_alu_res;
    assign valid_o   = r_valid;
    assign status_o  = r_status;

endmodule

// File: tb/tb_exe_alu_status.sv
// Self-checking bench for exe_alu_status: directed scenarios followed by
// randomized instructions, compared against an arithmetic reference model.
module tb_exe_alu_status;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [3:0]  exe_cmd_i;
    logic        s_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] alu_res_o;
    logic        valid_o;
    logic [3:0]  status_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_res;
    logic        m_valid;
    logic [3:0]  m_status;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint UMAX = 64'sd4294967295;

    exe_alu_status #(.DATA_W(32), .CMD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (valid_i),
        .exe_cmd_i (exe_cmd_i),
        .s_i       (s_i),
        .op1_i     (op1_i),
        .op2_i     (op2_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .alu_res_o (alu_res_o),
        .valid_o   (valid_o),
        .status_o  (status_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Arithmetic model: unsigned/signed math on wide integers, ARM flag rules
    function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] st,
                                    output logic [31:0] res, output logic [3:0] fl,
                                    output logic legal);
        longint ua, ub, sa, sb, full, sres, k;
        logic c, v;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = $signed(a);
        sb = $signed(b);
        c = st[1];
        v = st[0];
        legal = 1'b1;
        res = 32'd0;
        case (cmd)
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            4'b0010, 4'b0011: begin
                k = (cmd == 4'b0011 && st[1]) ? 64'sd1 : 64'sd0;
                full = ua + ub + k;
                res = full[31:0];
                c = (full > UMAX);
                sres = sa + sb + k;
                v = (sres > SMAX) || (sres < SMIN);
            end
            4'b0100, 4'b0101: begin
                k = (cmd == 4'b0101 && !st[1]) ? 64'sd1 : 64'sd0;
                full = ua - ub - k;
                res = full[31:0];
                c = (ua >= ub + k);
                sres = sa - sb - k;
                v = (sres > SMAX) || (sres < SMIN);
            end
            default: begin
                legal = 1'b0;
                res = 32'd0;
            end
        endcase
        fl = {res[31], (res == 32'd0), c, v};
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".res"}, alu_res_o, m_res);
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, m_valid});
        chk({tag, ".status"}, {28'd0, status_o}, {28'd0, m_status});
    endtask

    // One instruction: drive at negedge, clock it in, update model, check
    task automatic step(input string tag, input logic v, input logic [3:0] cmd,
                        input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic st, input logic fl);
        logic [31:0] r;
        logic [3:0]  f;
        logic        lg;
        @(negedge clk);
        valid_i = v; exe_cmd_i = cmd; s_i = s; op1_i = a; op2_i = b;
        stall_i = st; flush_i = fl;
        ref_alu(cmd, a, b, m_status, r, f, lg);
        @(posedge clk);
        if (st) begin
            m_res = m_res;
        end else if (fl) begin
            m_res = 32'd0;
            m_valid = 1'b0;
        end else begin
            m_res = r;
            m_valid = v;
            if (v && s && lg) m_status = f;
        end
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] pick_op();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        valid_i = 1'b0; exe_cmd_i = 4'b0000; s_i = 1'b0;
        op1_i = 32'd0; op2_i = 32'd0; stall_i = 1'b0; flush_i = 1'b0;
        m_res = 32'd0; m_valid = 1'b0; m_status = 4'b0000;

        // Reset state
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ADD overflow into sign bit -> N,V
        step("t1_add", 1'b1, 4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("t1_res_const", alu_res_o, 32'h8000_0000);
        chk("t1_st_const", {28'd0, status_o}, {28'd0, 4'b1001});

        // 3: SBC 0-0 with C=0 -> 0xFFFFFFFF, N only
        step("t3_sbc", 1'b1, 4'b0101, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("t3_res_const", alu_res_o, 32'hFFFF_FFFF);
        chk("t3_st_const", {28'd0, status_o}, {28'd0, 4'b1000});

        // 2: SUB 5-5 -> Z,C; then ADC 1+1 S=0 uses C -> 3, flags held
        step("t2_sub", 1'b1, 4'b0100, 1'b1, 32'd5, 32'd5, 1'b0, 1'b0);
        chk("t2_st_const", {28'd0, status_o}, {28'd0, 4'b0110});
        step("t2_adc", 1'b1, 4'b0011, 1'b0, 32'd1, 32'd1, 1'b0, 1'b0);
        chk("t2_adc_const", alu_res_o, 32'd3);
        chk("t2_adc_st", {28'd0, status_o}, {28'd0, 4'b0110});

        // 4: ADD under stall for two cycles, then released
        step("t4_stall0", 1'b1, 4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
        step("t4_stall1", 1'b1, 4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
        step("t4_release", 1'b1, 4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        chk("t4_st_const", {28'd0, status_o}, {28'd0, 4'b0110});

        // 5: flushed SUB keeps status; flush with stall holds everything
        step("t5_pre", 1'b1, 4'b0001, 1'b0, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
        step("t5_flush", 1'b1, 4'b0100, 1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
        step("t5_pre2", 1'b1, 4'b0001, 1'b0, 32'd0, 32'hCAFE_0001, 1'b0, 1'b0);
        step("t5_stfl", 1'b1, 4'b0100, 1'b1, 32'd5, 32'd7, 1'b1, 1'b1);
        chk("t5_hold_const", alu_res_o, 32'hCAFE_0001);

        // Illegal command with S=1: result 0, flags held
        step("t6_ill", 1'b1, 4'b1111, 1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
        // valid_i=0 with S: result loads, flags held
        step("t6_inv", 1'b0, 4'b0100, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0);

        // Randomized instructions
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), pick_op(), pick_op(),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        // 6: asynchronous reset between edges, mid-stream
        step("t6_pre", 1'b1, 4'b0100, 1'b1, 32'd3, 32'd9, 1'b0, 1'b0);
        @(negedge clk);
        valid_i = 1'b1; exe_cmd_i = 4'b0010; s_i = 1'b1;
        op1_i = 32'h8000_0000; op2_i = 32'h8000_0000;
        #2;
        rst_n = 1'b0;
        #1;
        m_res = 32'd0; m_valid = 1'b0; m_status = 4'b0000;
        check_all("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("t6_post", 1'b1, 4'b0100, 1'b1, 32'd3, 32'd9, 1'b0, 1'b0);
        step("t6_ill2", 1'b1, 4'b1111, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("t6_ill_st", {28'd0, status_o}, {28'd0, 4'b1000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
